btn_latch_ctrl: RTL

//   Sequences the button-to-LED latch path. Synchronizes and debounces both raw

---
 rtl/btn_latch_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/btn_latch_ctrl.sv
// Button-to-LED latch sequencer: 2-FF sync + debounce on two active-low buttons,
// one-cycle latch gate per commit press, LED shift register. Optional LED_TIMEOUT_EN.
module btn_latch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int LED_W           = 5,
  parameter int TIMEOUT_CYCLES  = 2700000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       btn,
  output logic [LED_W-1:0] LED,
  output logic             latch_en,
  output logic             latch_d,
  output logic             busy
);

  localparam int             DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || LED_W < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("btn_latch_ctrl: DEBOUNCE_CYCLES, TIMEOUT_CYCLES must be >= 1 and LED_W >= 2");
  end

  typedef enum logic [1:0] {IDLE, CAPTURE, SHIFT, WAIT_REL} state_t;

  state_t     state, state_nxt;
  logic [1:0] sync1, sync2;
  logic [1:0] pressed;
  logic [1:0] db;
  logic [1:0] db_prev;
  logic       press0;
  logic       rise1;

  // Sync regs reset to 1 so the released buttons are not mistaken for a press.
  // NOTE: non-blocking assignments for all flops so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  assign pressed = ~sync2;

  for (genvar i = 0; i < 2; i++) begin : g_db
    logic            stable;
    logic [DB_W-1:0] cnt;

    always_ff @(posedge clk) begin
      if (rst) begin
        stable <= 1'b0;
        cnt    <= '0;
      end else if (pressed[i] != stable) begin
        if (cnt == DB_LAST) begin
          stable <= ~stable;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end

    assign db[i] = stable;
  end

  always_ff @(posedge clk) begin
    if (rst) db_prev <= 2'b00;
    else     db_prev <= db;
  end

  assign press0 = db[0] & ~db_prev[0];
  assign rise1  = db[1] & ~db_prev[1];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: default assignment first keeps this combinational block latch-free.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (press0) state_nxt = CAPTURE;
      CAPTURE:  state_nxt = SHIFT;
      SHIFT:    state_nxt = WAIT_REL;
      WAIT_REL: if (!db[0]) state_nxt = IDLE;
    endcase
  end

  always_comb begin
    latch_en = (state == CAPTURE);
    busy     = (state != IDLE);
  end

`ifdef LED_TIMEOUT_EN
  localparam int             TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] idle_cnt;
  logic            idle_run;
  logic            idle_expire;

  assign idle_run    = (state == IDLE) && (LED != '0) && !press0;
  assign idle_expire = idle_run && (idle_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst)                          idle_cnt <= '0;
    else if (idle_run && !idle_expire) idle_cnt <= idle_cnt + 1'b1;
    else                              idle_cnt <= '0;
  end
`endif

  // latch_d is captured with the press and held until the next capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      LED     <= '0;
      latch_d <= 1'b0;
    end else begin
      if (state == IDLE && press0) latch_d <= db[1];
      if (state == SHIFT)                   LED <= {LED[LED_W-2:0], latch_d};
      else if (state == WAIT_REL && rise1)  LED <= '0;
`ifdef LED_TIMEOUT_EN
      else if (idle_expire)                 LED <= '0;
`endif
    end
  end

endmodule
